// File: rtl/case1_vec_driver.sv
// ---------------------------------------------------------------------------
// case1_vec_driver
//
// Stimulus/response engine for the 4-input / 3-output combinational "case1"
// block. It walks the DUT inputs {a,b,c,d} through all 16 combinations. For
// each vector it waits a programmable settle time, then samples {x,y,z} and
// compares the sample against a built-in golden function. Every sample is
// folded into a 16-bit MISR signature.
//
// Parameters
//   SETTLE  wait cycles between driving a vector and sampling it (1..15)
//   ERR_W   width of the mismatch counter (saturates at all-ones)
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               one-cycle pulse; begins a sweep when idle
//   busy                high from the cycle after an accepted start until done
//   done                one-cycle pulse when the sweep completes
//   vec_a..vec_d        DUT inputs a..d (vector bits 3..0)
//   dut_x, dut_y, dut_z DUT outputs x, y, z
//   err_cnt             mismatching vectors in the last sweep
//   first_fail          index of the first mismatching vector (0 when none)
//   fail_valid          any mismatch occurred in the last sweep
//   sig                 MISR signature of all sampled responses
// ---------------------------------------------------------------------------
module case1_vec_driver #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             vec_a,
  output logic             vec_b,
  output logic             vec_c,
  output logic             vec_d,
  input  logic             dut_x,
  input  logic             dut_y,
  input  logic             dut_z,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_fail,
  output logic             fail_valid,
  output logic [15:0]      sig
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    FIN
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  wait_cnt;

  logic        ga, gb, gc, gd;
  logic [2:0]  gold;
  logic [2:0]  resp;
  logic [15:0] sig_next;

  // Golden response for the vector currently being processed.
  always_comb begin
    ga   = idx[3];
    gb   = idx[2];
    gc   = idx[1];
    gd   = idx[0];
    gold = '0;
    gold[2] = (~ga & ~gb & ~(gc & gd)) | ((ga | gb) & ~gc & ~gd);
    gold[1] = ((ga & gb) ^ gc ^ gd) & ((ga & gb) ^ (gc | gd));
    gold[0] = ((ga | gb) & ~gc & ~gd) | (~(ga & gb) & gc & gd);
  end

  always_comb begin
    resp     = {dut_x, dut_y, dut_z};
    // Feedback taps 15, 11 and 4, with the response folded into the low bits.
    sig_next = {sig[14:0], sig[15] ^ sig[11] ^ sig[4]} ^ {13'b0, resp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vec_a      <= 1'b0;
      vec_b      <= 1'b0;
      vec_c      <= 1'b0;
      vec_d      <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      sig        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            sig        <= '0;
            idx        <= '0;
            state      <= DRIVE;
          end
        end

        DRIVE: begin
          {vec_a, vec_b, vec_c, vec_d} <= idx;
          wait_cnt <= SETTLE_L;
          state    <= WAIT;
        end

        // The counter is loaded with SETTLE, so WAIT lasts SETTLE cycles;
        // a count of 0 is treated like 1 so an illegal SETTLE cannot hang.
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          sig <= sig_next;
          if (resp != gold) begin
            if (err_cnt != '1) begin
              err_cnt <= err_cnt + ERR_W'(1);
            end
            if (!fail_valid) begin
              first_fail <= idx;
              fail_valid <= 1'b1;
            end
          end
          if (idx == 4'd15) begin
            // Outputs for FIN are registered here so that done, the busy
            // fall and the vector return to 0 all appear in the FIN cycle.
            done                         <= 1'b1;
            busy                         <= 1'b0;
            {vec_a, vec_b, vec_c, vec_d} <= 4'd0;
            state                        <= FIN;
          end else begin
            idx   <= idx + 4'd1;
            state <= DRIVE;
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/case1_vec_driver.md
Name: case1_vec_driver

Overview:
- Self-checking stimulus/response engine for the 4-input/3-output combinational `case1` logic.
- Drives the four DUT inputs (a, b, c, d) through all 16 combinations.
- Samples the returned x, y, z after a programmable settle time and compares each against a built-in golden function.
- Reports an error count, the first failing vector and a response signature; sits at the DUT boundary in the synthesis regression harness.

Parameters:
- SETTLE, 2, wait cycles between driving a vector and sampling the response (legal 1..15).
- ERR_W, 5, width of the error counter (must hold up to 16).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a sweep when idle.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse when the sweep completes.
- vec_a  output  1  DUT input a (= vector bit 3).
- vec_b  output  1  DUT input b (= vector bit 2).
- vec_c  output  1  DUT input c (= vector bit 1).
- vec_d  output  1  DUT input d (= vector bit 0).
- dut_x  input  1  DUT output x.
- dut_y  input  1  DUT output y.
- dut_z  input  1  DUT output z.
- err_cnt  output  ERR_W  count of mismatching vectors in the last sweep.
- first_fail  output  4  index of the first mismatching vector; 0 when none.
- fail_valid  output  1  high if any mismatch occurred in the last sweep.
- sig  output  16  MISR signature of all sampled responses.

Behaviour:
- Reset (asynchronous, rst_n low) forces all of the following to 0:
  - busy, done, vec_*, err_cnt, first_fail, fail_valid, sig;
  - FSM to IDLE; vector index and wait counter to 0.
- Golden function, with v = {a,b,c,d}:
  - gx = (~a & ~b & ~(c & d)) | ((a | b) & ~c & ~d)
  - gy = ((a & b) ^ c ^ d) & ((a & b) ^ (c | d))
  - gz = ((a | b) & ~c & ~d) | (~(a & b) & c & d)
- FSM states and transitions:
  - IDLE: wait for start. On start, clear err_cnt, first_fail, fail_valid and sig; set index to 0; go to DRIVE.
  - DRIVE: register vec_* = index; load wait counter with SETTLE; go to WAIT. vec_* is stable from here until the next DRIVE.
  - WAIT: decrement the counter; when it reaches 1, go to SAMPLE. Total cycles from DRIVE to SAMPLE = SETTLE.
  - SAMPLE: register {dut_x, dut_y, dut_z}, compare with the golden value of the current index, and update the MISR.
    - On mismatch: err_cnt += 1. If fail_valid == 0, set first_fail = index and fail_valid = 1.
    - If index == 15: go to FIN. Otherwise index += 1 and go to DRIVE.
  - FIN: done = 1 for one cycle; busy falls in the same cycle; vec_* returns to 0; go to IDLE.
- Cycles per vector = SETTLE + 2 (DRIVE + WAIT + SAMPLE). A full sweep = 16 × (SETTLE + 2) + 1 cycles including FIN.
- MISR update in SAMPLE, with r = {dut_x, dut_y, dut_z}:
  - sig_next = {sig[14:0], sig[15] ^ sig[11] ^ sig[4]} ^ {13'b0, r}
- Index wraps 15→0 only via a new start; it never increments past 15.
- start while busy is ignored; a running sweep is never restarted.
- start in the same cycle as the FIN done pulse is ignored. start is accepted only in IDLE.
- err_cnt saturates at 2^ERR_W − 1 if ERR_W is too small. The default parameter never saturates.
- Results (err_cnt, first_fail, fail_valid, sig) hold after done until the next accepted start.
- Reset asserted mid-sweep aborts immediately and reinitialises all state; no done pulse is produced.
- DUT inputs are sampled only in SAMPLE; glitches during WAIT have no effect.

Test Plan:
- Golden DUT model connected, SETTLE=2, single start → done after 65 cycles; err_cnt=0; fail_valid=0; first_fail=0. Spot-check responses: v=0000→xyz=100, v=1100→111, v=0011→001, v=1111→000.
- dut_y tied to 0, otherwise golden → err_cnt=7 (vectors 1, 2, 5, 6, 9, 10, 12); first_fail=1; fail_valid=1.
- dut_x, dut_y, dut_z tied to 0 → sig equals the value from the bench MISR model; err_cnt equals the count of vectors with nonzero golden output; first_fail=0.
- start pulsed again at cycle 20 of a sweep, and once more in the FIN cycle → both ignored; exactly one done; results unchanged versus the clean run.
- rst_n dropped during vector 7 WAIT, released, then start → all outputs 0 during reset, no done from the aborted sweep; the new sweep completes with the clean-run results.
- SETTLE=1 and SETTLE=15 → sweep lengths of 49 and 273 cycles; vec_* is held SETTLE cycles before each sample (check with a DUT model that delays its response by SETTLE−1 cycles: err_cnt=0).
